// File: rtl/change_dispenser.sv
// change_dispenser: ticket/change output stage of the ticket vending machine.
//
// A one-cycle start strobe, accepted only when idle, latches the ticket count
// (clamped to MAX_TICKETS) and the change due. The block then issues all
// tickets, followed by the change paid greedily in 10/5/1 coins. It issues one
// item per accepted actuator-ready cycle, and each pulse is followed by
// GAP_CYCLES recovery cycles.
//
// Optional feature macro: COIN_TALLY_EN adds saturating per-denomination coin
// counters (tally10_o/tally5_o/tally1_o). These counters are cleared only by reset.
//
// Ports:
//   clk_i          system clock, rising edge
//   rst_ni         asynchronous active-low reset
//   start_i        one-cycle strobe: latch ticket_cnt_i / change_i
//   ticket_cnt_i   tickets to issue (clamped to MAX_TICKETS)
//   change_i       change due, 0..127
//   act_ready_i    actuator can accept a pulse this cycle
//   busy_o         high from the cycle after start until done
//   ticket_pulse_o one-cycle ticket eject
//   coin_pulse_o   one-cycle coin eject
//   coin_val_o     coin value with coin_pulse_o (10/5/1), else 0
//   remain_o       change not yet dispensed
//   done_o         one-cycle completion strobe
module change_dispenser #(
  parameter int unsigned GAP_CYCLES  = 2,
  parameter int unsigned MAX_TICKETS = 5
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       start_i,
  input  logic [2:0] ticket_cnt_i,
  input  logic [6:0] change_i,
  input  logic       act_ready_i,
  output logic       busy_o,
  output logic       ticket_pulse_o,
  output logic       coin_pulse_o,
  output logic [3:0] coin_val_o,
  output logic [6:0] remain_o,
  output logic       done_o
`ifdef COIN_TALLY_EN
  ,
  output logic [7:0] tally10_o,
  output logic [7:0] tally5_o,
  output logic [7:0] tally1_o
`endif
);

  localparam logic [2:0]  MaxTk   = 3'(MAX_TICKETS);
  localparam int unsigned GapW    = (GAP_CYCLES > 2) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [GapW-1:0] GapLast = GapW'((GAP_CYCLES == 0) ? 0 : GAP_CYCLES - 1);

  typedef enum logic [2:0] {StIdle, StTicket, StCoin, StGap, StDone} state_e;

  state_e          state_q, state_d;
  logic [2:0]      tk_q, tk_d;
  logic [6:0]      rem_q, rem_d;
  logic [GapW-1:0] gap_cnt_q, gap_cnt_d;
  logic [3:0]      coin_sel;

  logic            busy_q, busy_d;
  logic            ticket_pulse_q, ticket_pulse_d;
  logic            coin_pulse_q, coin_pulse_d;
  logic [3:0]      coin_val_q, coin_val_d;
  logic            done_q, done_d;

  function automatic state_e pick_next(input logic [2:0] tk, input logic [6:0] rem);
    if (tk != 3'd0) return StTicket;
    if (rem != 7'd0) return StCoin;
    return StDone;
  endfunction

  // Greedy denomination for the next coin.
  always_comb begin
    coin_sel = 4'd1;
    if (rem_q >= 7'd10)     coin_sel = 4'd10;
    else if (rem_q >= 7'd5) coin_sel = 4'd5;
  end

  // State register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= StIdle;
    else         state_q <= state_d;
  end

  // Next-state and datapath next values.
  always_comb begin
    state_d   = state_q;
    tk_d      = tk_q;
    rem_d     = rem_q;
    gap_cnt_d = gap_cnt_q;
    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          tk_d    = (ticket_cnt_i > MaxTk) ? MaxTk : ticket_cnt_i;
          rem_d   = change_i;
          state_d = pick_next(tk_d, rem_d);
        end
      end
      StTicket: begin
        if (act_ready_i) begin
          tk_d      = tk_q - 3'd1;
          gap_cnt_d = '0;
          // Without a recovery gap the next decision follows the pulse directly.
          state_d   = (GAP_CYCLES == 0) ? pick_next(tk_d, rem_q) : StGap;
        end
      end
      StCoin: begin
        if (act_ready_i) begin
          rem_d     = rem_q - {3'b000, coin_sel};
          gap_cnt_d = '0;
          state_d   = (GAP_CYCLES == 0) ? pick_next(tk_q, rem_d) : StGap;
        end
      end
      StGap: begin
        if (gap_cnt_q == GapLast) state_d = pick_next(tk_q, rem_q);
        else                      gap_cnt_d = gap_cnt_q + GapW'(1);
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Output next values; every output is registered.
  always_comb begin
    ticket_pulse_d = (state_q == StTicket) && act_ready_i;
    coin_pulse_d   = (state_q == StCoin) && act_ready_i;
    coin_val_d     = coin_pulse_d ? coin_sel : 4'd0;
    done_d         = (state_q == StDone);
    busy_d         = (state_d != StIdle) && (state_q != StDone);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      tk_q           <= '0;
      rem_q          <= '0;
      gap_cnt_q      <= '0;
      busy_q         <= 1'b0;
      ticket_pulse_q <= 1'b0;
      coin_pulse_q   <= 1'b0;
      coin_val_q     <= '0;
      done_q         <= 1'b0;
    end else begin
      tk_q           <= tk_d;
      rem_q          <= rem_d;
      gap_cnt_q      <= gap_cnt_d;
      busy_q         <= busy_d;
      ticket_pulse_q <= ticket_pulse_d;
      coin_pulse_q   <= coin_pulse_d;
      coin_val_q     <= coin_val_d;
      done_q         <= done_d;
    end
  end

  assign busy_o         = busy_q;
  assign ticket_pulse_o = ticket_pulse_q;
  assign coin_pulse_o   = coin_pulse_q;
  assign coin_val_o     = coin_val_q;
  assign remain_o       = rem_q;
  assign done_o         = done_q;

`ifdef COIN_TALLY_EN
  logic [7:0] tally10_q, tally5_q, tally1_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      tally10_q <= '0;
      tally5_q  <= '0;
      tally1_q  <= '0;
    end else if (coin_pulse_d) begin
      if (coin_sel == 4'd10 && tally10_q != 8'hff) tally10_q <= tally10_q + 8'd1;
      if (coin_sel == 4'd5 && tally5_q != 8'hff)   tally5_q  <= tally5_q + 8'd1;
      if (coin_sel == 4'd1 && tally1_q != 8'hff)   tally1_q  <= tally1_q + 8'd1;
    end
  end

  assign tally10_o = tally10_q;
  assign tally5_o  = tally5_q;
  assign tally1_o  = tally1_q;
`endif

endmodule

// File: tb/tb_change_dispenser.sv
// Directed bench for change_dispenser with GAP_CYCLES=2 and MAX_TICKETS=5.
// Cycle index k counts rising edges after the edge that accepted start
// (k=0 is just after that edge). Outputs are sampled 1 time unit after each edge.
module tb_change_dispenser;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [2:0] tcnt = '0;
  logic [6:0] chg = '0;
  logic       act_ready = 1'b1;
  logic       busy, ticket_pulse, coin_pulse, done;
  logic [3:0] coin_val;
  logic [6:0] remain;
`ifdef COIN_TALLY_EN
  logic [7:0] tally10, tally5, tally1;
`endif

  change_dispenser #(.GAP_CYCLES(2), .MAX_TICKETS(5)) dut (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .start_i       (start),
    .ticket_cnt_i  (tcnt),
    .change_i      (chg),
    .act_ready_i   (act_ready),
    .busy_o        (busy),
    .ticket_pulse_o(ticket_pulse),
    .coin_pulse_o  (coin_pulse),
    .coin_val_o    (coin_val),
    .remain_o      (remain),
    .done_o        (done)
`ifdef COIN_TALLY_EN
    ,
    .tally10_o     (tally10),
    .tally5_o      (tally5),
    .tally1_o      (tally1)
`endif
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Event record filled by collect(): cycle, value (0 = ticket), remain after the pulse.
  int ev_k[$];
  int ev_val[$];
  int ev_rem[$];
  int done_k;
  int overlap;
  int busy_hi;
  int stray_val;

  task automatic start_order(input logic [2:0] t, input logic [6:0] c);
    start = 1'b1;
    tcnt  = t;
    chg   = c;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  // Runs until done or max_cyc cycles. act_ready is low for cycles 1..ready_low;
  // a second start (tk=1, change=3) is offered at cycle restart_k when nonzero.
  task automatic collect(input int max_cyc, input int ready_low, input int restart_k);
    ev_k.delete();
    ev_val.delete();
    ev_rem.delete();
    done_k    = -1;
    overlap   = 0;
    stray_val = 0;
    busy_hi   = busy ? 1 : 0;
    for (int k = 1; k <= max_cyc && done_k < 0; k++) begin
      act_ready = (k <= ready_low) ? 1'b0 : 1'b1;
      if (k == restart_k) begin
        start = 1'b1;
        tcnt  = 3'd1;
        chg   = 7'd3;
      end
      @(posedge clk);
      #1;
      start = 1'b0;
      if (ticket_pulse && coin_pulse) overlap++;
      if (!coin_pulse && coin_val != 4'd0) stray_val++;
      if (ticket_pulse) begin
        ev_k.push_back(k); ev_val.push_back(0); ev_rem.push_back(int'(remain));
      end
      if (coin_pulse) begin
        ev_k.push_back(k); ev_val.push_back(int'(coin_val)); ev_rem.push_back(int'(remain));
      end
      if (busy) busy_hi++;
      if (done) done_k = k;
    end
    act_ready = 1'b1;
  endtask

  task automatic test_reset;
    #12;
    n_cmp++;
    if ({busy, ticket_pulse, coin_pulse, coin_val, remain, done} !== 15'd0) begin
      n_bad++;
      $display("FAIL reset_outputs: got %b, expected all zero",
               {busy, ticket_pulse, coin_pulse, coin_val, remain, done});
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_basic;
    int exp_k[6]   = '{1, 4, 7, 10, 13, 16};
    int exp_val[6] = '{0, 0, 10, 5, 1, 1};
    int exp_rem[6] = '{17, 17, 7, 2, 1, 0};
    start_order(3'd2, 7'd17);
    n_cmp++;
    if (remain !== 7'd17) begin
      n_bad++; $display("FAIL basic_latch_remain: got %0d, expected 17", remain);
    end
    collect(40, 0, 0);
    n_cmp++;
    if (ev_k.size() != 6) begin
      n_bad++; $display("FAIL basic_pulse_count: got %0d, expected 6", ev_k.size());
    end else begin
      for (int i = 0; i < 6; i++) begin
        n_cmp++;
        if (ev_k[i] != exp_k[i] || ev_val[i] != exp_val[i] || ev_rem[i] != exp_rem[i]) begin
          n_bad++;
          $display("FAIL basic_pulse%0d: got k=%0d val=%0d rem=%0d, expected k=%0d val=%0d rem=%0d",
                   i, ev_k[i], ev_val[i], ev_rem[i], exp_k[i], exp_val[i], exp_rem[i]);
        end
      end
    end
    n_cmp++;
    if (done_k != 19) begin
      n_bad++; $display("FAIL basic_done_cycle: got %0d, expected 19", done_k);
    end
    n_cmp++;
    if (busy_hi != 19) begin
      n_bad++; $display("FAIL basic_busy_cycles: got %0d, expected 19", busy_hi);
    end
    n_cmp++;
    if (overlap != 0 || stray_val != 0) begin
      n_bad++;
      $display("FAIL basic_exclusive: got overlap=%0d stray=%0d, expected 0/0", overlap, stray_val);
    end
  endtask

  task automatic test_zero_order;
    start_order(3'd0, 7'd0);
    collect(10, 0, 0);
    n_cmp++;
    if (ev_k.size() != 0 || done_k != 1 || busy_hi != 1) begin
      n_bad++;
      $display("FAIL zero_order: got pulses=%0d done_k=%0d busy=%0d, expected 0/1/1",
               ev_k.size(), done_k, busy_hi);
    end
  endtask

  task automatic test_ready_stall;
    start_order(3'd1, 7'd5);
    collect(30, 4, 0);
    n_cmp++;
    if (ev_k.size() != 2) begin
      n_bad++; $display("FAIL stall_pulse_count: got %0d, expected 2", ev_k.size());
    end else begin
      n_cmp++;
      if (ev_k[0] != 5 || ev_val[0] != 0) begin
        n_bad++;
        $display("FAIL stall_ticket: got k=%0d val=%0d, expected k=5 val=0", ev_k[0], ev_val[0]);
      end
      n_cmp++;
      if (ev_k[1] != 8 || ev_val[1] != 5 || ev_rem[1] != 0) begin
        n_bad++;
        $display("FAIL stall_coin: got k=%0d val=%0d rem=%0d, expected k=8 val=5 rem=0",
                 ev_k[1], ev_val[1], ev_rem[1]);
      end
    end
    n_cmp++;
    if (done_k != 11) begin
      n_bad++; $display("FAIL stall_done_cycle: got %0d, expected 11", done_k);
    end
  endtask

  task automatic test_clamp_restart;
    int tickets;
    start_order(3'd7, 7'd0);
    collect(40, 0, 5);
    tickets = 0;
    foreach (ev_val[i]) if (ev_val[i] == 0) tickets++;
    n_cmp++;
    if (tickets != 5 || ev_k.size() != 5) begin
      n_bad++;
      $display("FAIL clamp_tickets: got tickets=%0d pulses=%0d, expected 5/5", tickets, ev_k.size());
    end
    n_cmp++;
    if (done_k != 16) begin
      n_bad++; $display("FAIL clamp_done_cycle: got %0d, expected 16", done_k);
    end
    // The ignored second start must not leave a pending order behind.
    collect(12, 0, 0);
    n_cmp++;
    if (ev_k.size() != 0 || done_k != -1) begin
      n_bad++;
      $display("FAIL clamp_no_residue: got pulses=%0d done_k=%0d, expected 0/-1",
               ev_k.size(), done_k);
    end
  endtask

  task automatic test_abort;
    int coins = 0;
    start_order(3'd0, 7'd30);
    for (int k = 1; k <= 20 && coins < 2; k++) begin
      @(posedge clk);
      #1;
      if (coin_pulse) coins++;
    end
    n_cmp++;
    if (coins != 2 || remain !== 7'd10) begin
      n_bad++;
      $display("FAIL abort_precondition: got coins=%0d remain=%0d, expected 2/10", coins, remain);
    end
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({busy, ticket_pulse, coin_pulse, coin_val, remain, done} !== 15'd0) begin
      n_bad++;
      $display("FAIL abort_outputs: got %b, expected all zero",
               {busy, ticket_pulse, coin_pulse, coin_val, remain, done});
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    collect(12, 0, 0);
    n_cmp++;
    if (ev_k.size() != 0 || done_k != -1 || busy_hi != 0) begin
      n_bad++;
      $display("FAIL abort_quiet: got pulses=%0d done_k=%0d busy=%0d, expected 0/-1/0",
               ev_k.size(), done_k, busy_hi);
    end
    start_order(3'd1, 7'd1);
    collect(20, 0, 0);
    n_cmp++;
    if (ev_k.size() != 2) begin
      n_bad++; $display("FAIL abort_rerun_count: got %0d, expected 2", ev_k.size());
    end else begin
      n_cmp++;
      if (ev_k[0] != 1 || ev_val[0] != 0 || ev_k[1] != 4 || ev_val[1] != 1 || ev_rem[1] != 0) begin
        n_bad++;
        $display("FAIL abort_rerun: got k=%0d,%0d val=%0d,%0d rem=%0d, expected 1,4 0,1 0",
                 ev_k[0], ev_k[1], ev_val[0], ev_val[1], ev_rem[1]);
      end
    end
    n_cmp++;
    if (done_k != 7) begin
      n_bad++; $display("FAIL abort_rerun_done: got %0d, expected 7", done_k);
    end
  endtask

`ifdef COIN_TALLY_EN
  task automatic test_tally;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    n_cmp++;
    if ({tally10, tally5, tally1} !== 24'd0) begin
      n_bad++;
      $display("FAIL tally_reset: got %0d/%0d/%0d, expected 0/0/0", tally10, tally5, tally1);
    end
    for (int n = 0; n < 2; n++) begin
      start_order(3'd0, 7'd16);
      collect(30, 0, 0);
    end
    n_cmp++;
    if (tally10 !== 8'd2 || tally5 !== 8'd2 || tally1 !== 8'd2) begin
      n_bad++;
      $display("FAIL tally_counts: got %0d/%0d/%0d, expected 2/2/2", tally10, tally5, tally1);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_zero_order();
    test_ready_stall();
    test_clamp_restart();
    test_abort();
`ifdef COIN_TALLY_EN
    test_tally();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
